// File: rtl/picoblaze_debounced_inport.sv
// Debounced 8-bit input port for KCPSM3: level, rising-edge event latch, interrupt mask
// and interrupt request with the interrupt/interrupt_ack handshake.
module picoblaze_debounced_inport #(
    parameter logic [7:0]  LEVEL_PORT_ID = 8'h01,
    parameter logic [7:0]  EVENT_PORT_ID = 8'h02,
    parameter logic [7:0]  MASK_PORT_ID  = 8'h03,
    parameter int unsigned TICK_CYCLES   = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_in,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam int unsigned CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    logic [7:0]      sync1_q, sync2_q;
    logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [7:0][1:0] stable_q, stable_d;
    logic [7:0]      level_q, level_d;
    logic [7:0]      event_q, event_d;
    logic [7:0]      mask_q, mask_d;
    logic [7:0]      in_port_q, in_port_d;
    logic            irq_q, irq_d;
    logic [7:0]      rise;
    logic            event_clr;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Each bit needs four consecutive differing ticks before its level flips.
    always_comb begin
        level_d  = level_q;
        stable_d = stable_q;
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (stable_q[i] == 2'd3) begin
                        level_d[i]  = ~level_q[i];
                        stable_d[i] = 2'd0;
                    end else begin
                        stable_d[i] = stable_q[i] + 2'd1;
                    end
                end else begin
                    stable_d[i] = 2'd0;
                end
            end
        end
    end

    // A new event in the clearing cycle survives the clear; same for interrupt vs. ack.
    always_comb begin
        rise      = level_d & ~level_q;
        event_clr = read_strobe && (port_id == EVENT_PORT_ID);
        event_d   = (event_clr ? 8'h00 : event_q) | rise;
        mask_d    = (write_strobe && (port_id == MASK_PORT_ID)) ? out_port : mask_q;
        irq_d     = (irq_q && !interrupt_ack) || (|(rise & mask_q));
    end

    always_comb begin
        in_port_d = 8'h00;
        if (port_id == LEVEL_PORT_ID) begin
            in_port_d = level_q;
        end else if (port_id == EVENT_PORT_ID) begin
            in_port_d = event_q;
        end else if (port_id == MASK_PORT_ID) begin
            in_port_d = mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            stable_q   <= '0;
            level_q    <= '0;
            event_q    <= '0;
            mask_q     <= '0;
            in_port_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            stable_q   <= stable_d;
            level_q    <= level_d;
            event_q    <= event_d;
            mask_q     <= mask_d;
            in_port_q  <= in_port_d;
            irq_q      <= irq_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

endmodule
